// File: rtl/shift_reg_univ.sv
// Universal shift register: SIPO capture with word framing, parallel load, serial shift-out, rotate.
// Latency: every operation lands on the next rising edge; q/pout are combinational from the register.
// No backpressure: en stalls all state (pvalid drops), and every mode encoding is accepted every cycle.
module shift_reg_univ #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             d,
    input  logic [WIDTH-1:0] pdata,
    output logic             q,
    output logic [WIDTH-1:0] pout,
    output logic             pvalid
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_ROT   = 2'b11
    } mode_e;

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pvalid_q, pvalid_d;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

    // Next-state: en low or hold freezes the register and counter; only the word-completing shift raises pvalid.
    always_comb begin
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        pvalid_d = 1'b0;
        if (en) begin
            case (mode_sel)
                MODE_SHIFT: begin
                    if (MSB_FIRST) begin
                        sreg_d = {sreg_q[WIDTH-2:0], d};
                    end else begin
                        sreg_d = {d, sreg_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        pvalid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                MODE_LOAD: begin
                    // A load restarts word framing; any partially collected word is dropped.
                    sreg_d = pdata;
                    cnt_d  = '0;
                end
                MODE_ROT: begin
                    if (MSB_FIRST) begin
                        sreg_d = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
                    end else begin
                        sreg_d = {sreg_q[0], sreg_q[WIDTH-1:1]};
                    end
                end
                default: begin
                    sreg_d = sreg_q;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset that overrides everything, including mid-word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_q   <= '0;
            cnt_q    <= '0;
            pvalid_q <= 1'b0;
        end else begin
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            pvalid_q <= pvalid_d;
        end
    end

    // q is the bit the next shift pushes out.
    assign q      = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign pout   = sreg_q;
    assign pvalid = pvalid_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: MSB-first and LSB-first instances share all inputs.
// Latency: outputs compared on each falling edge against an arithmetic reference model.
// No backpressure in the DUT; stimulus is directed sequences followed by random traffic.
module tb_shift_reg_univ;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       d = 1'b0;
    logic [7:0] pdata = 8'h00;

    logic       q1, q0, pv1, pv0;
    logic [7:0] pout1, pout0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .pdata(pdata),
        .q(q1), .pout(pout1), .pvalid(pv1)
    );

    shift_reg_univ #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .pdata(pdata),
        .q(q0), .pout(pout0), .pvalid(pv0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register values as integers, word framing as a count of shifts since reset/load.
    int  m1 = 0;
    int  m0 = 0;
    int  nbits = 0;
    int  ep = 0;
    bit  mvalid = 1'b0;

    always @(posedge clk) begin
        ep = 0;
        if (!rst_n) begin
            m1 = 0; m0 = 0; nbits = 0; mvalid = 1'b1;
        end else if (en) begin
            case (mode)
                2'b01: begin
                    m1 = ((m1 * 2) % 256) + int'(d);
                    m0 = (m0 / 2) + int'(d) * 128;
                    nbits = nbits + 1;
                    if (nbits == 8) begin
                        nbits = 0;
                        ep = 1;
                    end
                end
                2'b10: begin
                    m1 = int'(pdata); m0 = int'(pdata); nbits = 0;
                end
                2'b11: begin
                    m1 = ((m1 * 2) % 256) + (m1 / 128);
                    m0 = (m0 / 2) + (m0 % 2) * 128;
                end
                default: ;
            endcase
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("pout_msb", {24'b0, pout1}, m1);
            chk("q_msb", {31'b0, q1}, m1 / 128);
            chk("pvalid_msb", {31'b0, pv1}, ep);
            chk("pout_lsb", {24'b0, pout0}, m0);
            chk("q_lsb", {31'b0, q0}, m0 % 2);
            chk("pvalid_lsb", {31'b0, pv0}, ep);
        end
    end

    // Apply one set of inputs across one rising edge; returns at the following falling edge.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic dv, input logic [7:0] pd);
        rst_n = r; en = e; mode = m; d = dv; pdata = pd;
        @(negedge clk);
    endtask

    task automatic sh(input logic dv);
        step(1'b1, 1'b1, 2'b01, dv, 8'h00);
    endtask

    logic [7:0] seq = 8'b1011_0010;
    logic [7:0] a5 = 8'hA5;

    initial begin
        @(negedge clk);
        step(1'b0, 1'b1, 2'b01, 1'b1, 8'hFF);
        chk("reset_pout", {24'b0, pout1}, 32'h0);
        chk("reset_q", {31'b0, q1}, 32'h0);
        chk("reset_pvalid", {31'b0, pv1}, 32'h0);

        // SIPO framing, both bit orders, d = 1,0,1,1,0,0,1,0.
        for (int i = 0; i < 8; i++) begin
            sh(seq[7-i]);
            if (i < 7) chk("sipo_pv_early", {31'b0, pv1}, 32'h0);
        end
        chk("sipo_msb_word", {24'b0, pout1}, 32'hB2);
        chk("sipo_lsb_word", {24'b0, pout0}, 32'h4D);
        chk("sipo_pv_8th", {31'b0, pv1}, 32'h1);
        step(1'b1, 1'b1, 2'b00, 1'b0, 8'h00);
        chk("sipo_pv_one_cycle", {31'b0, pv1}, 32'h0);

        // PISO: load A5, shift out with d=0.
        step(1'b1, 1'b1, 2'b10, 1'b0, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            chk("piso_q", {31'b0, q1}, {31'b0, a5[7-i]});
            sh(1'b0);
        end
        chk("piso_final", {24'b0, pout1}, 32'h0);
        chk("piso_pv", {31'b0, pv1}, 32'h1);

        // Rotate.
        step(1'b1, 1'b1, 2'b10, 1'b0, 8'h81);
        step(1'b1, 1'b1, 2'b11, 1'b0, 8'h00);
        chk("rot_msb", {24'b0, pout1}, 32'h03);
        chk("rot_lsb", {24'b0, pout0}, 32'hC0);
        chk("rot_pv", {31'b0, pv1}, 32'h0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 2'b11, 1'b0, 8'h00);
        chk("rot_full", {24'b0, pout1}, 32'h81);

        // Gaps: 4 shifts, en low x3, hold x2, 4 shifts.
        step(1'b1, 1'b1, 2'b10, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) sh(1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2'b01, 1'b1, 8'h00);
            chk("gap_en_pv", {31'b0, pv1}, 32'h0);
        end
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 2'b00, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            sh(1'b0);
            chk("gap_pv", {31'b0, pv1}, (i == 3) ? 32'h1 : 32'h0);
        end
        chk("gap_word", {24'b0, pout1}, 32'hF0);

        // Streaming: 16 back-to-back shifts.
        for (int i = 0; i < 16; i++) begin
            sh(i[0]);
            chk("stream_pv", {31'b0, pv1}, (i == 7 || i == 15) ? 32'h1 : 32'h0);
        end

        // Reset mid-word.
        for (int i = 0; i < 5; i++) sh(1'b1);
        step(1'b0, 1'b1, 2'b01, 1'b1, 8'h00);
        chk("midrst_pout", {24'b0, pout1}, 32'h0);
        chk("midrst_pv", {31'b0, pv1}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            sh(1'b1);
            chk("midrst_pv_frame", {31'b0, pv1}, (i == 7) ? 32'h1 : 32'h0);
        end

        // Load mid-word.
        for (int i = 0; i < 5; i++) sh(1'b0);
        step(1'b1, 1'b1, 2'b10, 1'b0, 8'hFF);
        chk("midload_pout", {24'b0, pout1}, 32'hFF);
        for (int i = 0; i < 8; i++) begin
            sh(1'b0);
            chk("midload_pv_frame", {31'b0, pv1}, (i == 7) ? 32'h1 : 32'h0);
        end

        // Random traffic, mostly shifts, with occasional resets, stalls, loads and rotates.
        for (int i = 0; i < 3000; i++) begin
            int x;
            logic [1:0] m;
            x = int'($urandom_range(0, 9));
            m = (x < 6) ? 2'b01 : (x == 6) ? 2'b00 : (x == 7) ? 2'b10 : 2'b11;
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 5) != 0), m,
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: the next generation of the single-bit D flip-flop stage used in the SIPO shift-register work. It provides serial-in/parallel-out capture with word framing, parallel load, serial shift-out and rotate in one register of configurable width and bit order. It sits between a serial bit stream and word-wide logic, or the reverse, and flags each completed serial word.

## Interface
- WIDTH, 8, register width in bits; legal range is WIDTH >= 2.
- MSB_FIRST, 1, bit order. 1: shift toward MSB, serial input enters bit 0, q = bit WIDTH-1. 0: shift toward LSB, serial input enters bit WIDTH-1, q = bit 0.

- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
- en  input  1  clock enable for all state, including the counter and pvalid.
- mode  input  2  operation select: 00 hold, 01 shift, 10 parallel load, 11 rotate.
- d  input  1  serial data in; used only in mode 01.
- pdata  input  WIDTH  parallel load data; used only in mode 10.
- q  output  1  serial out; combinational from the register's output end bit.
- pout  output  WIDTH  register contents; combinational from the register.
- pvalid  output  1  registered one-cycle pulse; high while pout holds a freshly completed serial word.

## Operation
- State:
  - sreg, WIDTH bits.
  - cnt, $clog2(WIDTH) bits; counts shifted-in bits of the current word.
  - pvalid flop.
- Priority at each rising edge is: rst_n low, then en low, then mode.
- rst_n low: sreg = 0, cnt = 0, pvalid = 0. As a result q = 0 and pout = 0 from the next cycle. Reset overrides all other inputs, including mid-word.
- en low: sreg and cnt hold; pvalid = 0.
- mode 00 (hold): sreg and cnt hold; pvalid = 0.
- mode 01 (shift):
  - MSB_FIRST=1: sreg = {sreg[WIDTH-2:0], d}.
  - MSB_FIRST=0: sreg = {d, sreg[WIDTH-1:1]}.
  - If cnt == WIDTH-1: cnt wraps to 0 and pvalid = 1. Otherwise cnt increments and pvalid = 0.
- mode 10 (load): sreg = pdata, cnt = 0, pvalid = 0. A partially collected word is discarded.
- mode 11 (rotate): sreg rotates one place in the shift direction. The end bit re-enters at the opposite end: MSB_FIRST=1 is rotate-left, MSB_FIRST=0 is rotate-right. cnt holds; pvalid = 0.
- Word framing: a word completes on exactly the WIDTH-th enabled shift counted from the last reset or load. Enabled shifts need not be consecutive; hold, rotate and en-low cycles do not advance the count.
- Streaming: shift in every cycle for continuous back-to-back words. pvalid then pulses every WIDTH cycles with no gap cycle, and the first bit of the next word is accepted in the same cycle pvalid is high.
- q always shows the bit that the next shift will push out. Before a PISO shift-out, the first q value after a load is pdata's output end bit.

## Timing
- Single clock domain; no combinational path from inputs to outputs.
- Latency:
  - Load is visible on pout and q one cycle after the load edge.
  - pvalid rises on the same edge that shifts in the last bit. It is therefore coincident with the completed word on pout and lasts exactly one cycle.
- Reset is effective at the first rising edge with rst_n low. Outputs read 0 from then until the first non-hold operation after rst_n returns high.
- Out-of-range mode values do not exist; all 4 encodings are defined.

## Test plan
- Reset, then SIPO framing: WIDTH=8, MSB_FIRST=1, en=1, mode=01. Shift d = 1,0,1,1,0,0,1,0 → after the 8th edge pout = 8'hB2 and pvalid = 1 for exactly one cycle; pvalid = 0 during edges 1-7.
- LSB-first framing: MSB_FIRST=0, same d sequence → pout = 8'h4D with the pvalid pulse after the 8th edge.
- PISO: load pdata = 8'hA5, then 8 shifts with d=0 → q before each shift = 1,0,1,0,0,1,0,1; final pout = 8'h00; pvalid pulses after the 8th shift.
- Rotate: load 8'h81, then one mode 11 edge → pout = 8'h03, pvalid = 0. Seven further rotates → pout = 8'h81.
- Gaps and streaming:
  - Shift 4 bits, then en=0 for 3 cycles with mode=01, then mode 00 for 2 cycles, then shift 4 more → a single pvalid pulse on the 8th shift.
  - Then shift 16 bits continuously → pvalid pulses exactly on shifts 8 and 16, with no gap between words.
- Reset and load mid-word:
  - Shift 5 bits, then drive rst_n low for one edge → pout = 0, no pvalid. Shifting 8 new bits → pvalid only after the 8th.
  - Repeat with a load of 8'hFF after 5 bits instead of the reset → same framing: pvalid only after 8 further shifts.
